// File: rtl/mult_arb_pkg.sv
// rtl/mult_arb_pkg.sv - shared state encoding, port ids and grant helper for mult_arbiter
package mult_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LAUNCH = 2'b01,
        WAIT   = 2'b10,
        RESP   = 2'b11
    } arb_state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // A lone requester wins; on a tie the port that was not served last wins.
    function automatic logic pick_winner(input logic req0, input logic req1, input logic last_served);
        if (req0 && req1) begin
            return ~last_served;
        end
        if (req1) begin
            return PORT1;
        end
        return PORT0;
    endfunction

endpackage

// File: rtl/mult_arb_watchdog.sv
// rtl/mult_arb_watchdog.sv - WAIT-state cycle counter that flags a multiplier that never reports done
module mult_arb_watchdog #(
    parameter int TIMEOUT = 70
) (
    input  logic clock,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_count;

    // Count WAIT cycles; saturate so a stuck enable cannot wrap back to a small value.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != CW'(TIMEOUT))) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Count starts at 0 in the first WAIT cycle, so TIMEOUT-1 marks the last allowed cycle.
    assign o_expired = i_enable && (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin two-port arbiter and sequencer for the shared multiplier (watchdog build: MULT_ARB_WATCHDOG_EN)
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 70
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 i_req0,
    input  logic                 i_req1,
    input  logic [WIDTH-1:0]     i_a0,
    input  logic [WIDTH-1:0]     i_b0,
    input  logic [WIDTH-1:0]     i_a1,
    input  logic [WIDTH-1:0]     i_b1,
    input  logic                 i_mul_idle,
    input  logic                 i_mul_done,
    input  logic [2*WIDTH-1:0]   i_mul_product,
    output logic                 o_mul_start,
    output logic [WIDTH-1:0]     o_mul_a,
    output logic [WIDTH-1:0]     o_mul_b,
    output logic [2*WIDTH-1:0]   o_result,
    output logic                 o_done0,
    output logic                 o_done1,
    output logic                 o_err,
    output logic                 o_busy,
    output logic                 o_owner
);

    arb_state_t r_state;
    logic       r_last;
    logic       w_winner;
    logic       w_expired;

    assign w_winner = pick_winner(i_req0, i_req1, r_last);

`ifdef MULT_ARB_WATCHDOG_EN
    mult_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock     (clock),
        .rst       (rst),
        .i_clear   (r_state == LAUNCH),
        .i_enable  (r_state == WAIT),
        .o_expired (w_expired)
    );
`else
    logic [31:0] w_unused_timeout;
    assign w_unused_timeout = 32'(TIMEOUT);
    assign w_expired        = 1'b0;
`endif

    // Sequencer: grant, launch, wait for the multiplier, then pulse done to the owner.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_last      <= PORT1;
            o_mul_start <= 1'b0;
            o_mul_a     <= '0;
            o_mul_b     <= '0;
            o_result    <= '0;
            o_done0     <= 1'b0;
            o_done1     <= 1'b0;
            o_err       <= 1'b0;
            o_busy      <= 1'b0;
            o_owner     <= PORT0;
        end else begin
            o_mul_start <= 1'b0;
            o_done0     <= 1'b0;
            o_done1     <= 1'b0;
            o_err       <= 1'b0;
            case (r_state)
                IDLE: begin
                    if ((i_req0 || i_req1) && i_mul_idle) begin
                        o_owner     <= w_winner;
                        o_mul_a     <= (w_winner == PORT1) ? i_a1 : i_a0;
                        o_mul_b     <= (w_winner == PORT1) ? i_b1 : i_b0;
                        o_mul_start <= 1'b1;
                        o_busy      <= 1'b1;
                        r_state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (i_mul_done) begin
                        o_result <= i_mul_product;
                        o_done0  <= (o_owner == PORT0);
                        o_done1  <= (o_owner == PORT1);
                        r_state  <= RESP;
                    end else if (w_expired) begin
                        o_result <= '0;
                        o_err    <= 1'b1;
                        o_done0  <= (o_owner == PORT0);
                        o_done1  <= (o_owner == PORT1);
                        r_state  <= RESP;
                    end
                end
                RESP: begin
                    r_last  <= o_owner;
                    o_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Two-port arbiter and sequencer for the shared shift-add multiplier. It accepts multiply requests from two requesters (port 0: integer pipeline MULT/MULTU, port 1: auxiliary unit) and grants the multiplier round-robin. It registers the winner's operands, drives the multiplier controller's start/Idle/Done handshake, and returns the 2·WIDTH-bit product with a one-cycle done pulse to the owner.

## Interface
- WIDTH, 32, operand width; product is 2·WIDTH
- TIMEOUT, 70, max cycles in WAIT before abort (watchdog build only)

- clock  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req0 / req1  in  1  request; held high with operands stable until matching done
- a0, b0 / a1, b1  in  WIDTH  operands of port 0 / port 1
- mul_idle  in  1  multiplier controller Idle
- mul_done  in  1  multiplier controller Done (one-cycle)
- mul_product  in  2·WIDTH  multiplier product register
- mul_start  out  1  one-cycle start pulse to multiplier controller
- mul_a, mul_b  out  WIDTH  registered operands to multiplier datapath
- result  out  2·WIDTH  registered product, valid while done0/done1 high
- done0 / done1  out  1  one-cycle completion pulse to port 0 / port 1
- err  out  1  one-cycle abort flag, coincident with done (watchdog build only; otherwise tied 0)
- busy  out  1  high in every state except IDLE
- owner  out  1  id of current/last granted port

## Operation
- States (2-bit): IDLE=00, LAUNCH=01, WAIT=10, RESP=11.
- IDLE: if (req0|req1) and mul_idle: choose winner, latch its operands into mul_a/mul_b, set owner, go LAUNCH. Otherwise stay.
- Winner selection: a single requester wins. With both requesting, the port ≠ last-served pointer wins. The pointer updates in RESP and resets to 1, so port 0 wins the first tie.
- LAUNCH: mul_start=1, go WAIT.
- WAIT: on mul_done, capture mul_product into result, go RESP. req changes are ignored.
- RESP: done[owner]=1, update pointer to owner, go IDLE.
- All outputs are registered. done0/done1 are mutually exclusive. mul_start is high only in LAUNCH.
- Reset values: state IDLE; mul_start, done0, done1, err, busy, owner = 0; mul_a, mul_b, result = 0; pointer = 1.
- Reset mid-operation returns to IDLE immediately, with no done pulse. The multiplier is reset by the same rst.
- mul_idle low in IDLE blocks the grant; requests stay pending.
- A req dropped before done is a protocol violation. The operation still completes and the pulse still fires.

## Timing
- A req sampled high at edge E (state IDLE) puts the arbiter in LAUNCH at E+1, with mul_start high in that cycle. The multiplier sees start at edge E+2.
- done/result are high in the cycle after the cycle in which mul_done is high.
- Requester handshake: req must go low on the edge that ends its done cycle. The arbiter re-samples req in IDLE on the following edge.
- Back-to-back throughput: one operation per (multiplier latency + 3) cycles. No idle cycle is inserted beyond IDLE.

## Configuration
- MULT_ARB_WATCHDOG_EN defined:
  - A counter runs in WAIT, cleared on entry.
  - If TIMEOUT cycles pass without mul_done, the arbiter goes to RESP with result=0 and err=1 alongside done[owner].
  - The pointer still updates.
- Not defined: no counter, WAIT waits indefinitely, err is constant 0.

## Structure
- Shared package mult_arb_pkg: state encoding constants (IDLE/LAUNCH/WAIT/RESP) and port id constants PORT0=0, PORT1=1.
- One sub-module: mult_arb_watchdog (counter, width $clog2(TIMEOUT+1), inputs clear/enable, output expired).
  - Instantiated only under MULT_ARB_WATCHDOG_EN.

## Test plan
- Single request: req0, a0=3, b0=5 → one mul_start pulse; done0 for one cycle, 1 cycle after mul_done; result=15; done1 never.
- Simultaneous requests after reset: req0 (7×9) and req1 (2×4) → port 0 served first (result 63), then port 1 (result 8). Owner is 0 then 1.
- Fairness: req0 and req1 held continuously for 4 operations → grant order 0,1,0,1.
- Reset mid-operation: assert rst in WAIT → state IDLE, all outputs 0, no done. A new req1 (6×6) after release gives result=36 on done1.
- mul_idle held low for 5 cycles with req0 high → no mul_start until mul_idle rises; then normal completion.
- Watchdog build: suppress mul_done with TIMEOUT=10 → after 10 WAIT cycles, done0=1, err=1, result=0. Non-watchdog build: busy stays high.
